// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered result/status stage that sits directly behind the 16-bit
// structural ALU. Each accepted ALU result is stored together with its
// derived N/Z/C/V flags in a small circular FIFO guarded by a valid/ready
// handshake. Two sticky indicators (overflow seen, illegal opcode seen) are
// kept for the control path until it clears them.
//
// Parameters
//   WIDTH        datapath width, must match the ALU result width
//   DEPTH        FIFO entries, power of two and at least 2
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset, discards all entries at once
//   in_valid     upstream presents an ALU result this cycle
//   in_ready     stage can accept an entry (depends on occupancy only)
//   in_result    ALU result
//   in_carry     adder carry/borrow
//   in_overflow  adder overflow
//   in_opcode    opcode that produced in_result
//   out_valid    head entry available
//   out_ready    downstream consumes the head entry
//   out_result   head result, 0 while empty
//   out_flags    head flags {N,Z,C,V}, 0 while empty
//   count        current occupancy
//   sticky_v     an accepted entry had V=1 since the last clear
//   sticky_ill   an accepted entry had an illegal opcode since the last clear
//   clr_sticky   synchronous clear of both sticky bits (a same-cycle set wins)
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carry,
    input  logic                     in_overflow,
    input  logic [2:0]               in_opcode,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_v,
    output logic                     sticky_ill,
    input  logic                     clr_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        OPC_ARITH,
        OPC_LOGIC,
        OPC_ILLEGAL
    } op_class_e;

    // Field order gives the packed layout {N,Z,C,V} seen on out_flags.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic op_class_e classify(input logic [2:0] opcode);
        op_class_e cls;
        if (opcode[2:1] == 2'b00) begin
            cls = OPC_ARITH;
        end else if (opcode[2:1] == 2'b11) begin
            cls = OPC_ILLEGAL;
        end else begin
            cls = OPC_LOGIC;
        end
        return cls;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  mem_result_q [DEPTH];
    flags_t            mem_flags_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              sticky_v_q,   sticky_v_d;
    logic              sticky_ill_q, sticky_ill_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic push;
    logic pop;

    // Full means not ready even when a pop happens this cycle: no
    // pass-through, so in_ready never depends on out_ready.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid  && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Entry formation: result masking and flag derivation at push time
    // ------------------------------------------------------------------
    op_class_e        op_class;
    logic [WIDTH-1:0] entry_result;
    flags_t           entry_flags;

    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block so no path leaves it unassigned and infers a latch.
    always_comb begin
        op_class      = classify(in_opcode);
        entry_result  = in_result;
        entry_flags   = '0;

        if (op_class == OPC_ILLEGAL) begin
            // Illegal opcodes are still accepted, but carry a zero result.
            entry_result = '0;
        end

        // N, C and V are only meaningful for add/subtract.
        entry_flags.n = (op_class == OPC_ARITH) && in_result[WIDTH-1];
        entry_flags.z = (entry_result == '0);
        entry_flags.c = (op_class == OPC_ARITH) && in_carry;
        entry_flags.v = (op_class == OPC_ARITH) && in_overflow;
    end

    // ------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and sticky bits
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        sticky_v_d   = sticky_v_q;
        sticky_ill_d = sticky_ill_q;

        // DEPTH is a power of two, so natural pointer overflow is the
        // modulo-DEPTH wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a same-cycle set wins over clr_sticky.
        if (clr_sticky) begin
            sticky_v_d   = 1'b0;
            sticky_ill_d = 1'b0;
        end
        if (push && entry_flags.v) begin
            sticky_v_d = 1'b1;
        end
        if (push && (op_class == OPC_ILLEGAL)) begin
            sticky_ill_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sticky_v_q   <= 1'b0;
            sticky_ill_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sticky_v_q   <= sticky_v_d;
            sticky_ill_q <= sticky_ill_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; a slot is only ever read after
    // it has been written, and the outputs are gated to zero while empty,
    // so stale contents never become visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result_q[wr_ptr_q] <= entry_result;
            mem_flags_q[wr_ptr_q]  <= entry_flags;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: driven from registers only, zeroed while the FIFO is empty
    // ------------------------------------------------------------------
    assign out_result = out_valid ? mem_result_q[rd_ptr_q] : '0;
    assign out_flags  = out_valid ? mem_flags_q[rd_ptr_q]  : 4'b0000;
    assign count      = count_q;
    assign sticky_v   = sticky_v_q;
    assign sticky_ill = sticky_ill_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// Directed testbench for alu_result_stage (WIDTH=16, DEPTH=2).
// Inputs are driven and outputs sampled on the falling clock edge; state
// changes on the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_result;
    logic              in_carry;
    logic              in_overflow;
    logic [2:0]        in_opcode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [3:0]        out_flags;
    logic [1:0]        count;
    logic              sticky_v;
    logic              sticky_ill;
    logic              clr_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .in_opcode   (in_opcode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .count       (count),
        .sticky_v    (sticky_v),
        .sticky_ill  (sticky_ill),
        .clr_sticky  (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [15:0] result,
                         input logic carry, input logic ovf, input logic [2:0] opcode);
        in_valid    = valid;
        in_result   = result;
        in_carry    = carry;
        in_overflow = ovf;
        in_opcode   = opcode;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        idle();

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_count",      32'(count),      32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_out_flags",  32'(out_flags),  32'h0);
        check("rst_sticky_v",   32'(sticky_v),   32'd0);
        check("rst_sticky_ill", 32'(sticky_ill), 32'd0);
        rst_n = 1'b1;

        // ---------------- add with N,C,V ----------------
        drive(1'b1, 16'h8000, 1'b1, 1'b1, 3'b000);
        @(negedge clk);
        idle();
        check("add_valid",    32'(out_valid),  32'd1);
        check("add_result",   32'(out_result), 32'h8000);
        check("add_flags",    32'(out_flags),  32'hB);
        check("add_sticky_v", 32'(sticky_v),   32'd1);
        check("add_count",    32'(count),      32'd1);
        @(negedge clk);
        check("add_popped_valid",  32'(out_valid),  32'd0);
        check("add_popped_result", 32'(out_result), 32'h0);

        // ---------------- AND with zero result, carry masked ----------------
        drive(1'b1, 16'h0000, 1'b1, 1'b0, 3'b010);
        @(negedge clk);
        idle();
        check("and_flags",  32'(out_flags),  32'h4);
        check("and_result", 32'(out_result), 32'h0);
        @(negedge clk);

        // ---------------- logical op with MSB set: N,C,V masked ----------------
        drive(1'b1, 16'h8000, 1'b1, 1'b1, 3'b101);
        @(negedge clk);
        idle();
        check("logic_msb_result", 32'(out_result), 32'h8000);
        check("logic_msb_flags",  32'(out_flags),  32'h0);
        @(negedge clk);

        // ---------------- subtract negative result ----------------
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 3'b001);
        @(negedge clk);
        idle();
        check("sub_result", 32'(out_result), 32'hFFFF);
        check("sub_flags",  32'(out_flags),  32'h8);
        @(negedge clk);

        // ---------------- illegal opcode ----------------
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 3'b111);
        @(negedge clk);
        idle();
        check("ill_valid",      32'(out_valid),  32'd1);
        check("ill_result",     32'(out_result), 32'h0);
        check("ill_flags",      32'(out_flags),  32'h4);
        check("ill_sticky_ill", 32'(sticky_ill), 32'd1);
        check("ill_sticky_v",   32'(sticky_v),   32'd1);
        @(negedge clk);

        // ---------------- clear concurrent with a V=1 push ----------------
        drive(1'b1, 16'h0001, 1'b0, 1'b1, 3'b000);
        clr_sticky = 1'b1;
        @(negedge clk);
        idle();
        clr_sticky = 1'b0;
        check("clrset_sticky_v",   32'(sticky_v),   32'd1);
        check("clrset_sticky_ill", 32'(sticky_ill), 32'd0);
        check("clrset_flags",      32'(out_flags),  32'h1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("clr_sticky_v",   32'(sticky_v),   32'd0);
        check("clr_sticky_ill", 32'(sticky_ill), 32'd0);

        // ---------------- backpressure, full, no pass-through ----------------
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        check("full_count",    32'(count),      32'd2);
        check("full_in_ready", 32'(in_ready),   32'd0);
        check("full_head",     32'(out_result), 32'h0001);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        check("full_drop_count", 32'(count),      32'd2);
        check("full_drop_head",  32'(out_result), 32'h0001);
        // Pop while full with in_valid still high: the push must not land.
        out_ready = 1'b1;
        @(negedge clk);
        idle();
        check("drain1_result", 32'(out_result), 32'h0002);
        check("drain1_count",  32'(count),      32'd1);
        @(negedge clk);
        check("drain2_valid",  32'(out_valid),  32'd0);
        check("drain2_result", 32'(out_result), 32'h0);
        check("drain2_count",  32'(count),      32'd0);
        // Empty pop request must not underflow.
        @(negedge clk);
        check("empty_pop_count", 32'(count), 32'd0);

        // ---------------- streaming, pointer wrap ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 3'b011);
            @(negedge clk);
            check($sformatf("stream_result_%0d", i), 32'(out_result), 32'(16'h0010 + i));
            check($sformatf("stream_count_%0d", i),  32'(count),      32'd1);
        end
        idle();
        @(negedge clk);
        check("stream_end_valid", 32'(out_valid), 32'd0);

        // ---------------- asynchronous reset mid-cycle ----------------
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 1'b0, 1'b1, 3'b000);
        @(negedge clk);
        drive(1'b1, 16'h00BB, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        idle();
        check("pre_rst_count",    32'(count),    32'd2);
        check("pre_rst_sticky_v", 32'(sticky_v), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count",     32'(count),      32'd0);
        check("async_rst_out_valid", 32'(out_valid),  32'd0);
        check("async_rst_result",    32'(out_result), 32'h0);
        check("async_rst_flags",     32'(out_flags),  32'h0);
        check("async_rst_in_ready",  32'(in_ready),   32'd1);
        check("async_rst_sticky_v",  32'(sticky_v),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h00CC, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        idle();
        check("post_rst_result", 32'(out_result), 32'h00CC);
        check("post_rst_count",  32'(count),      32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result/status stage placed directly downstream of the 16-bit structural ALU. It captures each ALU result together with the adder carry and overflow, derives the N/Z/C/V status flags, and buffers entries in a small FIFO behind a valid/ready handshake. It also keeps sticky overflow and illegal-opcode indicators for the control path.

## Interface
Parameters:
- WIDTH, 16, datapath width; must match the ALU result width.
- DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- in_valid  input  1  upstream ALU presents a result this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  WIDTH  ALU result.
- in_carry  input  1  adder carry/borrow (Cas).
- in_overflow  input  1  adder overflow (Vas).
- in_opcode  input  3  opcode that produced in_result.
- out_valid  output  1  head entry is available.
- out_ready  input  1  downstream consumes the head entry.
- out_result  output  WIDTH  head result.
- out_flags  output  4  head flags {N,Z,C,V}.
- count  output  $clog2(DEPTH)+1  current occupancy.
- sticky_v  output  1  an accepted entry had V=1 since the last clear.
- sticky_ill  output  1  an accepted entry had an illegal opcode since the last clear.
- clr_sticky  input  1  synchronous clear of both sticky bits.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Opcode classes:
  - Arithmetic: 3'b000 add, 3'b001 subtract.
  - Logical: 3'b010..3'b101.
  - Illegal: 3'b110, 3'b111.
- Flag derivation at push, with arith = (in_opcode[2:1]==2'b00):
  - N = arith & in_result[WIDTH-1]
  - Z = (stored result == 0)
  - C = arith & in_carry
  - V = arith & in_overflow
- Illegal opcode: the entry is still accepted. Its stored result is 0 and its flags are 4'b0100. sticky_ill sets.
- sticky_v sets on a push whose V=1.
- clr_sticky clears both sticky bits. If clr_sticky and a set condition occur in the same cycle, the set wins and the bit reads 1.
- FIFO storage:
  - Circular buffer with write and read pointers, each wrapping modulo DEPTH.
  - count tracks occupancy: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - in_ready = (count < DEPTH). When full, in_ready is 0 even if a pop occurs that cycle; there is no pass-through.
  - out_valid = (count != 0).
  - out_result and out_flags drive the head entry when out_valid=1 and are forced to 0 when out_valid=0.
  - Entries leave in push order.
- Upstream may change in_* freely while in_ready=0. Downstream may deassert out_ready at any time; the head entry stays stable until it is popped.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, out_result=0, out_flags=0, sticky_v=0, sticky_ill=0. Pointers are 0.
- Reset mid-operation: all buffered entries are discarded immediately, asynchronously. Operation resumes on the first rising edge after rst_n deasserts.
- Latency: a push at edge k makes out_valid=1, with that data, from just after edge k when the FIFO was empty. There are no combinational paths from in_* to out_*.
- in_ready depends only on count. out_ready does not feed in_ready combinationally.
- Throughput: one entry per cycle in steady state, with simultaneous push and pop at count=1.
- Full: push is ignored and state is unchanged by in_valid.
- Empty: a pop request is ignored and count does not underflow.
- Pointer wrap from DEPTH−1 to 0 must preserve ordering.

## Test plan
- Reset, then push add {in_result=16'h8000, in_carry=1, in_overflow=1, in_opcode=000}:
  - Next cycle: out_valid=1, out_result=8000, out_flags=4'b1011, sticky_v=1.
- Push AND with in_result=0, in_carry=1, in_opcode=010 -> out_flags=4'b0100 (C masked, Z set).
- Push opcode 3'b111 with in_result=16'h1234 -> out_result=0, out_flags=4'b0100, sticky_ill=1.
  - clr_sticky in the same cycle as a new V=1 push -> sticky_v stays 1.
  - clr_sticky alone on the next cycle -> both stickies 0.
- Hold out_ready=0 and push 0x0001, 0x0002, 0x0003:
  - After two pushes, count=2 and in_ready=0; the third push is dropped.
  - Release out_ready -> outputs 0x0001 then 0x0002, then out_valid=0 with out_result=0.
- Continuous in_valid=1, out_ready=1 for 10 cycles with incrementing results -> count stays ≤1 after the first cycle, all 10 values exit in order, and pointers wrap correctly.
- Assert rst_n=0 mid-cycle with count=2 -> count=0, out_valid=0 and outputs=0 immediately, before the next clock edge.
